// File: rtl/enemies_pkg.sv
// Shared types and default sizing for the enemy collision detector.
package enemies_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } state_e;

    localparam int DEF_NUM_ENEMIES     = 4;
    localparam int DEF_COOLDOWN_FRAMES = 3;

    // Cooldown counter width; COOLDOWN_FRAMES must fit, i.e. at most 15.
    localparam int CD_W = 4;

endpackage

// File: rtl/collision_cooldown.sv
// Per-enemy cooldown: after a direction-change pulse the enemy is held off
// for COOLDOWN_FRAMES report cycles.
module collision_cooldown
    import enemies_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
    input  logic clk,
    input  logic resetN,
    input  logic load,
    input  logic tick,
    output logic ready
);

    logic [CD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CD_W'(COOLDOWN_FRAMES);
        end else if (tick && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ready = (cnt_q == '0);

endmodule

// File: rtl/enemies_collision_detector.sv
// Per-frame enemy/border/enemy and player/enemy collision detection with
// registered one-cycle pulses reported two clocks after startOfFrame.
module enemies_collision_detector
    import enemies_pkg::*;
#(
    parameter int NUM_ENEMIES     = DEF_NUM_ENEMIES,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
    parameter int HIT_COUNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic [NUM_ENEMIES-1:0]     enemyDrawingRequest,
    input  logic                       borderDrawingRequest,
    input  logic                       playerDrawingRequest,
    output logic [NUM_ENEMIES-1:0]     changeDirection,
    output logic                       playerHit,
    output logic [HIT_COUNT_WIDTH-1:0] hitCount
);

    state_e                     state_q, state_d;
    logic [NUM_ENEMIES-1:0]     coll_flag_q, coll_flag_d;
    logic [NUM_ENEMIES-1:0]     coll_snap_q, coll_snap_d;
    logic                       player_flag_q, player_flag_d;
    logic                       player_snap_q, player_snap_d;
    logic [NUM_ENEMIES-1:0]     change_dir_q, change_dir_d;
    logic                       player_hit_q, player_hit_d;
    logic [HIT_COUNT_WIDTH-1:0] hit_count_q, hit_count_d;

    logic [NUM_ENEMIES-1:0]     enemy_coll;
    logic                       player_coll;
    logic [NUM_ENEMIES-1:0]     cd_ready;
    logic                       in_report;

    // An enemy collides with the border or with any other enemy; with a single
    // enemy the "others" mask is empty, leaving only the border term.
    always_comb begin
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            enemy_coll[i] = enemyDrawingRequest[i] &
                            (borderDrawingRequest |
                             (|(enemyDrawingRequest & ~(NUM_ENEMIES'(1) << i))));
        end
        player_coll = playerDrawingRequest & (|enemyDrawingRequest);
    end

    assign in_report = (state_q == REPORT);

    // NOTE: every signal gets its default first so no path through the case
    // leaves a value unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        coll_flag_d   = coll_flag_q;
        coll_snap_d   = coll_snap_q;
        player_flag_d = player_flag_q;
        player_snap_d = player_snap_q;
        change_dir_d  = '0;
        player_hit_d  = 1'b0;
        hit_count_d   = hit_count_q;

        case (state_q)
            IDLE: begin
                if (startOfFrame) state_d = SCAN;
            end
            SCAN: begin
                if (startOfFrame) begin
                    // The startOfFrame pixel belongs to the new frame.
                    coll_snap_d   = coll_flag_q;
                    player_snap_d = player_flag_q;
                    coll_flag_d   = enemy_coll;
                    player_flag_d = player_coll;
                    state_d       = REPORT;
                end else begin
                    coll_flag_d   = coll_flag_q | enemy_coll;
                    player_flag_d = player_flag_q | player_coll;
                end
            end
            REPORT: begin
                coll_flag_d   = coll_flag_q | enemy_coll;
                player_flag_d = player_flag_q | player_coll;
                change_dir_d  = coll_snap_q & cd_ready;
                player_hit_d  = player_snap_q;
                if (player_snap_q && hit_count_q != '1) begin
                    hit_count_d = hit_count_q + 1'b1;
                end
                state_d = SCAN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= IDLE;
            coll_flag_q   <= '0;
            coll_snap_q   <= '0;
            player_flag_q <= 1'b0;
            player_snap_q <= 1'b0;
            change_dir_q  <= '0;
            player_hit_q  <= 1'b0;
            hit_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            coll_flag_q   <= coll_flag_d;
            coll_snap_q   <= coll_snap_d;
            player_flag_q <= player_flag_d;
            player_snap_q <= player_snap_d;
            change_dir_q  <= change_dir_d;
            player_hit_q  <= player_hit_d;
            hit_count_q   <= hit_count_d;
        end
    end

    for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_cooldown
        collision_cooldown #(
            .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
        ) u_cooldown (
            .clk    (clk),
            .resetN (resetN),
            .load   (change_dir_d[g]),
            .tick   (in_report),
            .ready  (cd_ready[g])
        );
    end

    assign changeDirection = change_dir_q;
    assign playerHit       = player_hit_q;
    assign hitCount        = hit_count_q;

endmodule

// File: doc/enemies_collision_detector.md
ENEMIES_COLLISION_DETECTOR -- requirements
Module: enemies_collision_detector

Interface
REQ-001 SHALL have parameter NUM_ENEMIES, default 4, number of enemy objects checked.
REQ-002 SHALL have parameter COOLDOWN_FRAMES, default 3, frames an enemy is blocked from a new changeDirection pulse after receiving one.
REQ-003 SHALL have parameter HIT_COUNT_WIDTH, default 8, width of the player-hit counter.
REQ-004 SHALL have port clk  input  1  system clock; the only clock.
REQ-005 SHALL have port resetN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port startOfFrame  input  1  one-cycle pulse at frame start.
REQ-007 SHALL have port enemyDrawingRequest  input  NUM_ENEMIES  per-enemy pixel-inside-bracket flags.
REQ-008 SHALL have port borderDrawingRequest  input  1  current pixel belongs to the screen border or a wall.
REQ-009 SHALL have port playerDrawingRequest  input  1  current pixel belongs to the player.
REQ-010 SHALL have port changeDirection  output  NUM_ENEMIES  per-enemy one-cycle reverse-direction pulse.
REQ-011 SHALL have port playerHit  output  1  one-cycle pulse, player touched any enemy last frame.
REQ-012 SHALL have port hitCount  output  HIT_COUNT_WIDTH  saturating count of frames with playerHit.

Function
REQ-013 SHALL implement a state machine with states IDLE, SCAN, REPORT.
REQ-014 IDLE: entered on reset; leaves to SCAN on startOfFrame; no outputs asserted; pixel collisions ignored.
REQ-015 SCAN: each cycle, enemy i collides if enemyDrawingRequest[i] AND (borderDrawingRequest OR any enemyDrawingRequest[j], j!=i); the sticky flag collFlag[i] is set.
REQ-016 SCAN: each cycle, playerFlag is set when playerDrawingRequest AND any enemyDrawingRequest.
REQ-017 SCAN with startOfFrame: the flags are copied to snapshots, the flags are loaded with that cycle's pixel collisions (the new frame), and the state goes to REPORT.
REQ-018 REPORT lasts exactly one cycle, then the state returns to SCAN; pixel collisions in REPORT set the flags.
REQ-019 In REPORT, changeDirection[i] SHALL equal snapshot[i] AND cooldown[i]==0; the output is a registered one-cycle pulse in the cycle after REPORT (latency 2 clk from startOfFrame).
REQ-020 cooldown[i] SHALL load COOLDOWN_FRAMES when enemy i pulses; otherwise it decrements once per REPORT while nonzero; it never wraps below 0.
REQ-021 playerHit SHALL pulse with the same timing as changeDirection when the player snapshot is set; it has no cooldown.
REQ-022 hitCount SHALL increment on each playerHit pulse and saturate at all-ones.
REQ-023 startOfFrame arriving in REPORT SHALL be ignored (it is illegal back-to-back input); the state goes to SCAN and the flags are not snapshotted.
REQ-024 A collision that exists only on the startOfFrame cycle SHALL belong to the new frame and not to the frame being reported.
REQ-025 An enemy with no other enemies (NUM_ENEMIES=1) SHALL detect border collisions only.

Reset
REQ-026 The resetN low level SHALL force state IDLE, all flags, snapshots and cooldowns to 0, changeDirection to 0, playerHit to 0 and hitCount to 0, immediately and independent of clk.
REQ-027 Reset asserted mid-frame or in REPORT SHALL discard pending collisions; no pulse follows the release of reset.

Structure
REQ-028 Package enemies_pkg SHALL hold the state enum type (IDLE/SCAN/REPORT), the default NUM_ENEMIES and COOLDOWN_FRAMES, and the cooldown counter width constant.
REQ-029 The per-enemy cooldown SHALL be the sub-module collision_cooldown (inputs: load, tick; output: ready), instantiated NUM_ENEMIES times via generate.

Verification
REQ-030 Reset, startOfFrame, then enemy0 overlaps the border for 5 pixels in frame 1, then the next startOfFrame -> changeDirection=4'b0001 for exactly one cycle, 2 clk after that startOfFrame.
REQ-031 Enemies 1 and 2 overlap each other in frame 1 -> changeDirection=4'b0110 pulse; the same overlap in frames 2-4 -> no pulse; frame 5 overlap -> pulse again (COOLDOWN_FRAMES=3).
REQ-032 Player overlaps enemy3 in 300 consecutive frames -> 300 playerHit pulses; hitCount reaches 255 and holds.
REQ-033 Collision pixel coincident only with the startOfFrame cycle of frame 2 -> no pulse at the frame-2 start; the pulse arrives at the frame-3 start.
REQ-034 resetN low for 1 cycle mid-frame after enemy0 hit the border -> all outputs 0; the next startOfFrame gives no pulse (the block passes through IDLE).
REQ-035 Pixel collisions before the first startOfFrame after reset -> ignored; no pulse at the second startOfFrame.
